// File: rtl/seg_scan_if.sv
// seg_scan_if: display-bus bundle observed by seg_scan_decoder.
//   an          digit strobes, active-low, one low bit selects a digit
//   seg         segments, active-low, [7:1]=a..g, [0]=dp
//   clr         synchronous clear of captured data and error flag
//   value       decoded nibbles, digit i at [4i+3:4i]
//   digit_ok    last capture of digit i was a legal hex glyph
//   dp          decimal point lit at last capture of digit i
//   frame_valid one-cycle pulse when every digit has been captured
//   err         sticky illegal-glyph flag
// master drives the display bus and clr; slave is the decoder.
interface seg_scan_if #(
    parameter int DIGITS = 8
);
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic                clr;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   digit_ok;
    logic [DIGITS-1:0]   dp;
    logic                frame_valid;
    logic                err;

    modport master (
        output an, seg, clr,
        input  value, digit_ok, dp, frame_valid, err
    );

    modport slave (
        input  an, seg, clr,
        output value, digit_ok, dp, frame_valid, err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: passive monitor for a multiplexed seven-segment bus.
// Registers the digit strobes and segments, waits for a pattern to be stable
// for STABLE_CYCLES samples, then decodes the glyph into a per-digit nibble.
// Ports:
//   clk    single clock, all bus inputs synchronous to it
//   rst_n  asynchronous active-low reset
//   bus    seg_scan_if.slave (an/seg/clr in; value/digit_ok/dp/frame_valid/err out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_WAIT  | no legal strobe sampled (blank or ghosting)
// ST_SETTLE| legal strobe sampled, counting identical samples
// ST_HELD  | current pattern already captured, wait for it to change
module seg_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    seg_scan_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ZW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HELD} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       count, count_nxt;
    logic [DIGITS-1:0]   an_q, an_p;
    logic [7:0]          seg_q, seg_p;
    logic [ZW-1:0]       zeros_cnt;
    logic [IW-1:0]       idx;
    logic                legal, same, capture;
    logic [4:0]          glyph;
    logic [DIGITS-1:0]   mask_q, mask_nxt;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   ok_q, dp_q;
    logic                fv_q, err_q;

    // {legal, nibble} for a SEG[7:1] pattern
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        case (g)
            7'b0000001: return 5'h10;
            7'b1001111: return 5'h11;
            7'b0010010: return 5'h12;
            7'b0000110: return 5'h13;
            7'b1001100: return 5'h14;
            7'b0100100: return 5'h15;
            7'b0100000: return 5'h16;
            7'b0001101: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0000100: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b1100000: return 5'h1B;
            7'b0110001: return 5'h1C;
            7'b1000010: return 5'h1D;
            7'b0110000: return 5'h1E;
            7'b0111000: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= '1;
            an_p  <= '1;
            seg_p <= '1;
        end else begin
            an_q  <= bus.an;
            seg_q <= bus.seg;
            an_p  <= an_q;
            seg_p <= seg_q;
        end
    end

    always_comb begin
        zeros_cnt = '0;
        idx       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) begin
                zeros_cnt = zeros_cnt + 1'b1;
                idx       = i[IW-1:0];
            end
        end
    end

    assign legal    = (zeros_cnt == ZW'(1));
    assign same     = ({an_q, seg_q} == {an_p, seg_p});
    assign glyph    = decode_glyph(seg_q[7:1]);
    assign mask_nxt = mask_q | ~an_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Capture fires on the edge where the count would reach STABLE_CYCLES,
    // so a pattern first registered at edge k is captured at edge k+STABLE_CYCLES.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        capture   = 1'b0;
        if (!legal) begin
            state_nxt = ST_WAIT;
            count_nxt = '0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (!same) begin
                        count_nxt = CW'(1);
                    end else if (count == COUNT_LAST) begin
                        capture   = 1'b1;
                        state_nxt = ST_HELD;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!same) begin
                        state_nxt = ST_SETTLE;
                        count_nxt = CW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_SETTLE;
                    count_nxt = CW'(1);
                end
            endcase
        end
    end

    // clr takes priority over a capture in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            ok_q    <= '0;
            dp_q    <= '0;
            err_q   <= 1'b0;
            fv_q    <= 1'b0;
            mask_q  <= '0;
        end else begin
            fv_q <= 1'b0;
            if (bus.clr) begin
                value_q <= '0;
                ok_q    <= '0;
                dp_q    <= '0;
                err_q   <= 1'b0;
                mask_q  <= '0;
            end else if (capture) begin
                dp_q[idx] <= ~seg_q[0];
                if (glyph[4]) begin
                    value_q[4*idx +: 4] <= glyph[3:0];
                    ok_q[idx]           <= 1'b1;
                end else begin
                    ok_q[idx] <= 1'b0;
                    err_q     <= 1'b1;
                end
                if (&mask_nxt) begin
                    mask_q <= '0;
                    fv_q   <= 1'b1;
                end else begin
                    mask_q <= mask_nxt;
                end
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_ok    = ok_q;
    assign bus.dp          = dp_q;
    assign bus.frame_valid = fv_q;
    assign bus.err         = err_q;
endmodule
